instr_burst_writer: RTL and testbench
=====================================

// Module: instr_burst_writer
// PURPOSE
//  Parametrised instruction-memory loader. Accepts bursts of 1..MAX_WORDS instruction words over a
//  valid/ready handshake and writes them one word per cycle into an internal single-port RAM at a
//  running write pointer. A registered read port serves the fetch stage. Adds bounds checking,
//  optional wrap-around, pointer rewind, a done pulse and sticky error reporting.
// PARAMETERS
//  WORD_W     32    width of one instruction word
//  MAX_WORDS  6     maximum words per burst (in_data lanes)
//  DEPTH      1024  RAM depth in words; power of two
//  ADDR_W     $clog2(DEPTH)      pointer/address width
//  CNT_W      $clog2(MAX_WORDS+1) width of in_count
//  WRAP_EN    0     1: pointer wraps modulo DEPTH; 0: bursts that would overrun are rejected
// PORTS
//  clk        in   1                 rising-edge clock
//  rst_n      in   1                 reset; asynchronous, active-low
//  in_valid   in   1                 burst offered
//  in_ready   out  1                 burst accepted when in_valid & in_ready
//  in_data    in   MAX_WORDS*WORD_W  lane k = in_data[k*WORD_W +: WORD_W]; lane 0 written first
//  in_count   in   CNT_W             number of valid lanes in burst
//  ptr_clr    in   1                 rewind write pointer to 0 (honoured only when idle)
//  rd_addr    in   ADDR_W            fetch address
//  rd_data    out  WORD_W            RAM[rd_addr], 1-cycle latency
//  wr_ptr     out  ADDR_W            next address to be written
//  done       out  1                 1-cycle pulse after last word of a burst is written
//  err        out  1                 sticky: illegal count or overrun rejected; cleared by ptr_clr
// BEHAVIOUR
//  Reset (async assert, sync deassert assumed upstream): state IDLE, wr_ptr=0, in_ready=0 during
//   reset then 1, done=0, err=0, rd_data=0. RAM contents are not reset.
//  FSM: IDLE -> WRITE on accepted legal burst; WRITE -> IDLE after word count-1 written.
//  IDLE: in_ready=1 unless ptr_clr=1. On handshake, lanes and count are captured into a holding
//   register; the first word is written on the NEXT cycle, at wr_ptr; one word per cycle after that.
//   Burst of n words: words land in cycles 1..n after the handshake. wr_ptr increments per write.
//   done pulses in the cycle after the last write, and the FSM is back in IDLE in that same cycle,
//   so back-to-back bursts are possible.
//  WRITE: in_ready=0; in_valid ignored, so the producer must hold in_data/in_count stable.
//  Illegal count (0 or >MAX_WORDS): burst consumed (handshake completes), nothing written,
//   err<=1, wr_ptr unchanged, no done.
//  Overrun: WRAP_EN=0 and wr_ptr+in_count > DEPTH (compute at ADDR_W+1 bits): burst consumed,
//   nothing written, err<=1. WRAP_EN=1: the address wraps DEPTH-1 -> 0 with no error.
//  Exactly filling the RAM (wr_ptr+count == DEPTH) is legal; wr_ptr becomes 0 (mod DEPTH) afterwards.
//   A later burst with WRAP_EN=0 is then checked against a pointer of 0, so software must ptr_clr
//   before reloading.
//  ptr_clr in IDLE: wr_ptr<=0, err<=0, in_ready=0 that cycle (clear beats a concurrent burst).
//   ptr_clr in WRITE: ignored.
//  Read: rd_data <= RAM[rd_addr] every cycle. Same-address read and write in one cycle returns the
//   OLD word (read-first).
//  Reset mid-burst: the burst is abandoned and the FSM returns to IDLE. Words already written stay
//   in the RAM; no done is issued.
// STRUCTURE
//  Shared package instr_mem_pkg: WORD_W default, the state enum {IDLE, WRITE}, and the err-cause
//   localparams.
//  One sub-module, spram_rf (single-port, write-enable, read-first, registered read), sized by
//   WORD_W/DEPTH. The FSM, holding register, lane mux and pointer logic live in this file.
// TESTING
//  1 Burst count=2 data {B,A} at ptr 0 -> RAM[0]=A, RAM[1]=B; done 3 cycles after handshake;
//    wr_ptr=2.
//  2 Bursts count=3 then count=6, back to back -> 9 contiguous words; in_ready low 3 and 6 cycles
//    respectively; two done pulses.
//  3 WRAP_EN=0, DEPTH=8, wr_ptr=6, count=3 -> no writes, err=1, wr_ptr=6; ptr_clr -> wr_ptr=0, err=0.
//  4 WRAP_EN=1, DEPTH=8, wr_ptr=6, count=4 -> RAM[6],[7],[0],[1] written; wr_ptr=2; err=0.
//  5 count=0 and count=7 -> each consumed in 1 cycle; err=1; no done; RAM unchanged.
//  6 rst_n low after 2nd word of a 5-word burst -> immediate IDLE, wr_ptr=0, done never pulses;
//    RAM[0..1] keep their new values.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_mem_pkg;

    localparam int WORD_W_DEF = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Reason a burst was rejected at the handshake.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_COUNT   = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;

endpackage

// File: rtl/instr_burst_writer_spram_rf.sv
// Single-port register-file RAM: one write port, registered read-first read port.
module spram_rf #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the array gives the old word on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_burst_writer.sv
// Instruction-memory loader: accepts bursts of words on a valid/ready handshake and
// writes them one per cycle at a running pointer into an internal RAM.
module instr_burst_writer
    import instr_mem_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int MAX_WORDS = 6,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int CNT_W     = $clog2(MAX_WORDS + 1),
    parameter bit WRAP_EN   = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MAX_WORDS*WORD_W-1:0] in_data,
    input  logic [CNT_W-1:0]            in_count,
    input  logic                        ptr_clr,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [WORD_W-1:0]           rd_data,
    output logic [ADDR_W-1:0]           wr_ptr,
    output logic                        done,
    output logic                        err
);

    localparam int                SUM_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // Handshake: a burst transfers on a rising clock edge where in_valid and in_ready
    // are both high; in_ready is high only while idle, out of reset and not clearing.
    state_t                      state;
    state_t                      state_nxt;
    logic [MAX_WORDS*WORD_W-1:0] hold_data;
    logic [CNT_W-1:0]            hold_count;
    logic [CNT_W-1:0]            idx;
    logic                        accept;
    logic                        last_word;
    logic                        ram_we;
    logic [1:0]                  err_cause;
    logic [SUM_W-1:0]            ptr_sum;
    logic [WORD_W-1:0]           lane_word;

    assign accept    = in_valid && in_ready;
    assign last_word = (idx == hold_count - CNT_ONE);
    assign ptr_sum   = {1'b0, wr_ptr} + SUM_W'(in_count);

    always_comb begin
        err_cause = ERR_NONE;
        if (in_count == '0 || in_count > CNT_W'(MAX_WORDS)) begin
            err_cause = ERR_COUNT;
        end else if (!WRAP_EN && ptr_sum > SUM_W'(DEPTH)) begin
            err_cause = ERR_OVERRUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && err_cause == ERR_NONE) state_nxt = WRITE;
            WRITE:   if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        ram_we   = 1'b0;
        case (state)
            IDLE:    in_ready = rst_n && !ptr_clr;
            WRITE:   ram_we   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        lane_word = '0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (idx == CNT_W'(k)) begin
                lane_word = hold_data[k*WORD_W +: WORD_W];
            end
        end
    end

    // The pointer wraps naturally at DEPTH (power of two); an exact fill lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            hold_data  <= '0;
            hold_count <= '0;
            idx        <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && ptr_clr) begin
                wr_ptr <= '0;
                err    <= 1'b0;
            end else if (accept) begin
                if (err_cause != ERR_NONE) begin
                    err <= 1'b1;
                end else begin
                    hold_data  <= in_data;
                    hold_count <= in_count;
                    idx        <= '0;
                end
            end
            if (ram_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                idx    <= idx + CNT_ONE;
                if (last_word) begin
                    done <= 1'b1;
                end
            end
        end
    end

    spram_rf #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (lane_word),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_instr_burst_writer.sv
// Bench for instr_burst_writer: a no-wrap instance (DEPTH 16) and a wrap instance (DEPTH 8)
// driven with directed and random bursts against a behavioural memory model.
module tb_instr_burst_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   in_valid;
    logic [1:0]   ptr_clr;
    logic [191:0] in_data;
    logic [2:0]   in_count;
    logic [3:0]   rd_addr_a;
    logic [2:0]   rd_addr_b;
    logic [1:0]   in_ready;
    logic [1:0]   done;
    logic [1:0]   err;
    logic [31:0]  rd_data_a;
    logic [31:0]  rd_data_b;
    logic [3:0]   wr_ptr_a;
    logic [2:0]   wr_ptr_b;

    int           tests = 0;
    int           fails = 0;
    int unsigned  cyc = 0;

    // Reference model: plain arrays indexed by instance.
    int           depth [2] = '{16, 8};
    bit           wrap [2] = '{1'b0, 1'b1};
    logic [31:0]  mem_m [2][16];
    bit           written [2][16];
    int           ptr_m [2];
    bit           err_m [2];
    logic [19:0]  done_q0 [$];
    logic [19:0]  done_q1 [$];

    instr_burst_writer #(.WORD_W(32), .MAX_WORDS(6), .DEPTH(16), .WRAP_EN(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .in_count(in_count), .ptr_clr(ptr_clr[0]), .rd_addr(rd_addr_a),
        .rd_data(rd_data_a), .wr_ptr(wr_ptr_a), .done(done[0]), .err(err[0])
    );

    instr_burst_writer #(.WORD_W(32), .MAX_WORDS(6), .DEPTH(8), .WRAP_EN(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .in_count(in_count), .ptr_clr(ptr_clr[1]), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .wr_ptr(wr_ptr_b), .done(done[1]), .err(err[1])
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int ptr_of(input int i);
        return (i == 0) ? int'(wr_ptr_a) : int'(wr_ptr_b);
    endfunction

    function automatic bit is_legal(input int i, input int n);
        if (n == 0 || n > 6) return 1'b0;
        if (!wrap[i] && ptr_m[i] + n > depth[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic status(input int i);
        check($sformatf("wr_ptr%0d", i), ptr_of(i), ptr_m[i]);
        check($sformatf("err%0d", i), 32'(err[i]), 32'(err_m[i]));
    endtask

    // Model update at the handshake; abort_k > 0 models a burst cut short by reset.
    task automatic model_accept(input int i, input int n, input logic [191:0] data,
                                input int unsigned hs, input int abort_k);
        int w;
        int a;
        if (!is_legal(i, n)) begin
            err_m[i] = 1'b1;
        end else begin
            w = (abort_k > 0) ? abort_k : n;
            for (int k = 0; k < w; k++) begin
                a = (ptr_m[i] + k) % depth[i];
                mem_m[i][a]   = data[k*32 +: 32];
                written[i][a] = 1'b1;
            end
            if (abort_k == 0) begin
                ptr_m[i] = (ptr_m[i] + n) % depth[i];
                if (i == 0) done_q0.push_back({16'(hs + 1 + n), 4'(ptr_m[i])});
                else        done_q1.push_back({16'(hs + 1 + n), 4'(ptr_m[i])});
            end
        end
    endtask

    // Driver: called at a negedge; returns at the negedge after the handshake.
    task automatic send(input int i, input int n, input logic [191:0] data, input int abort_k);
        int guard;
        int unsigned hs;
        guard = 0;
        while (!in_ready[i] && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (!in_ready[i]) begin
            fails++;
            $display("FAIL send%0d: got in_ready=0 for %0d cycles, required 1", i, guard);
            return;
        end
        in_data     = data;
        in_count    = n[2:0];
        in_valid[i] = 1'b1;
        hs          = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        model_accept(i, n, data, hs, abort_k);
    endtask

    task automatic wait_idle(input int i, output int lowcnt);
        lowcnt = 0;
        while (!in_ready[i] && lowcnt < 60) begin
            @(negedge clk);
            lowcnt++;
        end
    endtask

    task automatic burst(input int i, input int n);
        logic [191:0] data;
        int exp_low;
        int lowcnt;
        for (int k = 0; k < 6; k++) data[k*32 +: 32] = $urandom;
        exp_low = is_legal(i, n) ? n : 0;
        send(i, n, data, 0);
        wait_idle(i, lowcnt);
        check($sformatf("ready_low%0d n=%0d", i, n), lowcnt, exp_low);
        status(i);
    endtask

    task automatic rd_check(input int i, input int a);
        if (!written[i][a]) return;
        if (i == 0) rd_addr_a = a[3:0];
        else        rd_addr_b = a[2:0];
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rd%0d[%0d]", i, a), (i == 0) ? rd_data_a : rd_data_b, mem_m[i][a]);
    endtask

    task automatic clr(input int i, input bit with_valid);
        ptr_clr[i] = 1'b1;
        if (with_valid) begin
            in_count    = 3'd1;
            in_valid[i] = 1'b1;
        end
        #1;
        check($sformatf("clr_ready%0d", i), 32'(in_ready[i]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        ptr_clr[i]  = 1'b0;
        in_valid[i] = 1'b0;
        ptr_m[i]    = 0;
        err_m[i]    = 1'b0;
        #1;
        status(i);
        check($sformatf("post_clr_ready%0d", i), 32'(in_ready[i]), 32'd1);
    endtask

    // Scoreboard monitor for done pulses: expected cycle and pointer.
    task automatic mon_done(input int i);
        logic [19:0] e;
        int sz;
        sz = (i == 0) ? done_q0.size() : done_q1.size();
        tests++;
        if (sz == 0) begin
            fails++;
            $display("FAIL done%0d: got unexpected pulse at cycle %0d, required none", i, cyc);
        end else begin
            e = (i == 0) ? done_q0.pop_front() : done_q1.pop_front();
            if (e[19:4] != cyc[15:0] || int'(e[3:0]) != ptr_of(i)) begin
                fails++;
                $display("FAIL done%0d: got cycle %0d ptr %0d, required cycle %0d ptr %0d",
                         i, cyc[15:0], ptr_of(i), e[19:4], e[3:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (done[0]) mon_done(0);
        if (done[1]) mon_done(1);
    end

    initial begin
        logic [191:0] d;
        int lowcnt;
        in_valid  = '0;
        ptr_clr   = '0;
        in_data   = '0;
        in_count  = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        ptr_m     = '{0, 0};
        err_m     = '{1'b0, 1'b0};
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 16; a++) written[i][a] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ready%0d", i), 32'(in_ready[i]), 32'd0);
            status(i);
        end
        check("rst_rd_a", rd_data_a, 32'd0);
        check("rst_rd_b", rd_data_b, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst_a", 32'(in_ready[0]), 32'd1);

        // Two-word burst: lane 0 lands at address 0
        d = '0;
        d[31:0]  = 32'hAAAA_0001;
        d[63:32] = 32'hBBBB_0002;
        send(0, 2, d, 0);
        wait_idle(0, lowcnt);
        check("t1_ready_low", lowcnt, 2);
        status(0);
        rd_check(0, 0);
        rd_check(0, 1);

        // Back-to-back 3 then 6 words
        clr(0, 1'b0);
        burst(0, 3);
        burst(0, 6);
        for (int a = 0; a < 9; a++) rd_check(0, a);

        // Overrun rejection without wrap, then exact fill
        burst(0, 5);
        burst(0, 3);
        check("t3_ptr14", ptr_of(0), 14);
        burst(0, 3);
        burst(0, 2);
        check("exact_fill_ptr0", ptr_of(0), 0);
        clr(0, 1'b0);

        // Wrap-around instance: 6 then 4 wraps through 7 -> 0
        burst(1, 6);
        burst(1, 4);
        for (int a = 0; a < 8; a++) rd_check(1, a);

        // Illegal counts
        burst(0, 0);
        clr(0, 1'b0);
        burst(0, 7);
        rd_check(0, 0);
        rd_check(0, 8);

        // Clear beats a concurrent burst
        clr(0, 1'b1);

        // Reset in the middle of a five-word burst
        for (int k = 0; k < 6; k++) d[k*32 +: 32] = $urandom;
        send(0, 5, d, 2);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        ptr_m = '{0, 0};
        err_m = '{1'b0, 1'b0};
        @(negedge clk);
        check("midrst_ready", 32'(in_ready[0]), 32'd0);
        status(0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        status(0);
        status(1);
        for (int a = 0; a < 4; a++) rd_check(0, a);

        // Random bursts
        for (int it = 0; it < 60; it++) begin
            int i;
            i = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) clr(i, $urandom_range(0, 1) == 1);
            burst(i, $urandom_range(0, 7));
            rd_check(i, $urandom_range(0, depth[i] - 1));
        end

        repeat (5) @(negedge clk);
        check("done_q0_empty", done_q0.size(), 0);
        check("done_q1_empty", done_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
